// File: rtl/mem_arbiter_if.sv
// One line-transaction channel: request, optional write-data beat and read-response beats.
// The arbiter is the slave of each cache channel and the master of the memory channel.
`timescale 1ns/1ps
interface mem_arbiter_if #(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128
);
  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_BITS-1:0]   req_addr;
  logic                   req_rw;
  logic                   req_data_valid;
  logic                   req_data_ready;
  logic [DATA_BITS-1:0]   req_data_bits;
  logic [DATA_BITS/8-1:0] req_data_mask;
  logic                   resp_valid;
  logic [DATA_BITS-1:0]   resp_data;

  modport master (
    output req_valid, req_addr, req_rw, req_data_valid, req_data_bits, req_data_mask,
    input  req_ready, req_data_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr, req_rw, req_data_valid, req_data_bits, req_data_mask,
    output req_ready, req_data_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between the instruction and data caches, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise dc has fixed priority.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int ADDR_BITS  = 28,
  parameter int DATA_BITS  = 128,
  parameter int READ_BEATS = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave  ic,
  mem_arbiter_if.slave  dc,
  mem_arbiter_if.master mem
);
  localparam int BEAT_W = (READ_BEATS > 1) ? $clog2(READ_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(READ_BEATS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                req_done_q, req_done_d;
  logic                data_done_q, data_done_d;
  logic                last_owner_q, last_owner_d;

  logic                   o_valid, o_rw, o_dvalid;
  logic [ADDR_BITS-1:0]   o_addr;
  logic [DATA_BITS-1:0]   o_dbits;
  logic [DATA_BITS/8-1:0] o_dmask;
  logic                   grant_dc;
  logic                   own_req_ready, own_data_ready, own_resp_valid;
  logic                   req_hs, data_hs;

  // Owner's request fields; only meaningful while a valid is forwarded.
  assign o_valid  = owner_q ? dc.req_valid      : ic.req_valid;
  assign o_addr   = owner_q ? dc.req_addr       : ic.req_addr;
  assign o_rw     = owner_q ? dc.req_rw         : ic.req_rw;
  assign o_dvalid = owner_q ? dc.req_data_valid : ic.req_data_valid;
  assign o_dbits  = owner_q ? dc.req_data_bits  : ic.req_data_bits;
  assign o_dmask  = owner_q ? dc.req_data_mask  : ic.req_data_mask;

`ifdef MEM_ARB_RR_EN
  assign grant_dc = dc.req_valid && (!ic.req_valid || !last_owner_q);
`else
  assign grant_dc = dc.req_valid;
`endif

  assign mem.req_addr      = o_addr;
  assign mem.req_rw        = o_rw;
  assign mem.req_data_bits = o_dbits;
  assign mem.req_data_mask = o_dmask;

  assign ic.req_ready      = own_req_ready  && !owner_q;
  assign dc.req_ready      = own_req_ready  &&  owner_q;
  assign ic.req_data_ready = own_data_ready && !owner_q;
  assign dc.req_data_ready = own_data_ready &&  owner_q;
  assign ic.resp_valid     = own_resp_valid && !owner_q;
  assign dc.resp_valid     = own_resp_valid &&  owner_q;
  assign ic.resp_data      = mem.resp_data;
  assign dc.resp_data      = mem.resp_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      beat_q       <= '0;
      req_done_q   <= 1'b0;
      data_done_q  <= 1'b0;
      last_owner_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      beat_q       <= beat_d;
      req_done_q   <= req_done_d;
      data_done_q  <= data_done_d;
      last_owner_q <= last_owner_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    owner_d            = owner_q;
    beat_d             = beat_q;
    req_done_d         = req_done_q;
    data_done_d        = data_done_q;
    last_owner_d       = last_owner_q;
    mem.req_valid      = 1'b0;
    mem.req_data_valid = 1'b0;
    own_req_ready      = 1'b0;
    own_data_ready     = 1'b0;
    own_resp_valid     = 1'b0;
    req_hs             = 1'b0;
    data_hs            = 1'b0;

    case (state_q)
      IDLE: begin
        if (ic.req_valid || dc.req_valid) begin
          owner_d     = grant_dc;
          req_done_d  = 1'b0;
          data_done_d = 1'b0;
          state_d     = ADDR;
        end
      end
      ADDR: begin
        mem.req_valid = o_valid && !req_done_q;
        own_req_ready = mem.req_ready && !req_done_q;
        req_hs        = o_valid && mem.req_ready && !req_done_q;
        if (o_rw) begin
          mem.req_data_valid = o_dvalid && !data_done_q;
          own_data_ready     = mem.req_data_ready && !data_done_q;
          data_hs            = o_dvalid && mem.req_data_ready && !data_done_q;
        end
        req_done_d  = req_done_q || req_hs;
        data_done_d = data_done_q || data_hs;
        // A requester withdrawing before acceptance must not wedge the port.
        if (!req_done_q && !o_valid) begin
          state_d = IDLE;
        end else if (!o_rw) begin
          if (req_hs) begin
            state_d = RESP;
            beat_d  = '0;
          end
        end else if (req_done_d && data_done_d) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
        end
      end
      RESP: begin
        own_resp_valid = mem.resp_valid;
        if (mem.resp_valid) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            state_d      = IDLE;
            last_owner_d = owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: expected read beats / write beats queued at stimulus time.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AB = 28;
  localparam int DB = 128;
  localparam int RB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) ic_if ();
  mem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) dc_if ();
  mem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) mem_if ();

  mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .READ_BEATS(RB)) dut (
    .clk   (clk),
    .reset (rst_n),
    .ic    (ic_if),
    .dc    (dc_if),
    .mem   (mem_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          port;
    logic [DB-1:0] data;
  } beat_t;

  typedef struct packed {
    logic [DB-1:0]   data;
    logic [DB/8-1:0] mask;
  } wr_t;

  beat_t sb[$];
  wr_t   wsb[$];
  int    vectors = 0;
  int    miscompares = 0;

  task automatic clear_inputs();
    ic_if.req_valid = 1'b0;      ic_if.req_addr = '0;      ic_if.req_rw = 1'b0;
    ic_if.req_data_valid = 1'b0; ic_if.req_data_bits = '0; ic_if.req_data_mask = '0;
    dc_if.req_valid = 1'b0;      dc_if.req_addr = '0;      dc_if.req_rw = 1'b0;
    dc_if.req_data_valid = 1'b0; dc_if.req_data_bits = '0; dc_if.req_data_mask = '0;
    mem_if.req_ready = 1'b0;     mem_if.req_data_ready = 1'b0;
    mem_if.resp_valid = 1'b0;    mem_if.resp_data = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    ic_if.req_valid = 1'b1; dc_if.req_valid = 1'b1;
    mem_if.req_ready = 1'b1; mem_if.req_data_ready = 1'b1; mem_if.resp_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({ic_if.req_ready, ic_if.req_data_ready, ic_if.resp_valid, dc_if.req_ready,
         dc_if.req_data_ready, dc_if.resp_valid, mem_if.req_valid, mem_if.req_data_valid} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b %b %b %b %b %b %b %b, required all 0",
               ic_if.req_ready, ic_if.req_data_ready, ic_if.resp_valid, dc_if.req_ready,
               dc_if.req_data_ready, dc_if.resp_valid, mem_if.req_valid, mem_if.req_data_valid);
    end
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    beat_t e;
    ic_if.req_valid = 1'b1; ic_if.req_addr = 28'h0000123; ic_if.req_rw = 1'b0;
    mem_if.req_ready = 1'b1;
    #1;
    vectors++;
    if (mem_if.req_valid !== 1'b0 || ic_if.req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_gate: mem_req_valid=%b ic_req_ready=%b, required 0 0", mem_if.req_valid, ic_if.req_ready);
    end
    @(negedge clk); #1;
    vectors++;
    if ({mem_if.req_valid, mem_if.req_rw, mem_if.req_addr} !== {1'b1, 1'b0, 28'h0000123}) begin
      miscompares++;
      $display("FAIL read_fwd: valid=%b rw=%b addr=%h, required 1 0 0000123", mem_if.req_valid, mem_if.req_rw, mem_if.req_addr);
    end
    vectors++;
    if ({ic_if.req_ready, dc_if.req_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL read_ready: ic=%b dc=%b, required 1 0", ic_if.req_ready, dc_if.req_ready);
    end
    @(negedge clk);
    ic_if.req_valid = 1'b0; mem_if.req_ready = 1'b0;
    for (int i = 0; i < RB + 1; i++) begin
      mem_if.resp_valid = 1'b1;
      mem_if.resp_data  = DB'(32'hA + i);
      if (i < RB) sb.push_back('{port: 1'b0, data: DB'(32'hA + i)});
      #1;
      vectors++;
      if (sb.size() == 0) begin
        if (ic_if.resp_valid || dc_if.resp_valid) begin
          miscompares++;
          $display("FAIL read_extra_beat: resp_valid ic=%b dc=%b, required 0 0", ic_if.resp_valid, dc_if.resp_valid);
        end
      end else begin
        e = sb.pop_front();
        if (ic_if.resp_valid !== !e.port || dc_if.resp_valid !== e.port || ic_if.resp_data !== e.data) begin
          miscompares++;
          $display("FAIL read_beat%0d: ic=%b dc=%b data=%h, required ic=%b dc=%b data=%h", i,
                   ic_if.resp_valid, dc_if.resp_valid, ic_if.resp_data, !e.port, e.port, e.data);
        end
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_write();
    wr_t w;
    int n_rdy, n_drdy, rdy_at, drdy_at;
    n_rdy = 0; n_drdy = 0; rdy_at = -1; drdy_at = -1;
    dc_if.req_valid = 1'b1; dc_if.req_addr = 28'h0000456; dc_if.req_rw = 1'b1;
    dc_if.req_data_valid = 1'b1; dc_if.req_data_bits = DB'(32'h1234); dc_if.req_data_mask = 16'hFFFF;
    wsb.push_back('{data: DB'(32'h1234), mask: 16'hFFFF});
    mem_if.req_ready = 1'b0; mem_if.req_data_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (k >= 1) dc_if.req_data_valid = 1'b0;
      if (k >= 3) dc_if.req_valid = 1'b0;
      mem_if.req_ready = (k == 2);
      #1;
      if (dc_if.req_ready) begin n_rdy++; rdy_at = k; end
      if (dc_if.req_data_ready) begin n_drdy++; drdy_at = k; end
      if (mem_if.req_data_valid && mem_if.req_data_ready) begin
        vectors++;
        if (wsb.size() == 0) begin
          miscompares++;
          $display("FAIL write_data_extra: unexpected data beat %h, required none", mem_if.req_data_bits);
        end else begin
          w = wsb.pop_front();
          if ({mem_if.req_rw, mem_if.req_data_bits, mem_if.req_data_mask} !== {1'b1, w.data, w.mask}) begin
            miscompares++;
            $display("FAIL write_data: rw=%b data=%h mask=%h, required 1 %h %h",
                     mem_if.req_rw, mem_if.req_data_bits, mem_if.req_data_mask, w.data, w.mask);
          end
        end
      end
      if (k == 1) begin
        vectors++;
        if (mem_if.req_valid !== 1'b1 || mem_if.req_addr !== 28'h0000456) begin
          miscompares++;
          $display("FAIL write_wait_req: mem_req_valid=%b addr=%h, required 1 0000456", mem_if.req_valid, mem_if.req_addr);
        end
      end
      if (k == 3) begin
        vectors++;
        if (mem_if.req_valid !== 1'b0 || dc_if.req_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL write_idle: mem_req_valid=%b dc_req_ready=%b, required 0 0", mem_if.req_valid, dc_if.req_ready);
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (n_rdy != 1 || n_drdy != 1 || rdy_at != 2 || drdy_at != 0 || wsb.size() != 0) begin
      miscompares++;
      $display("FAIL write_pulses: req_ready %0d@%0d data_ready %0d@%0d pending %0d, required 1@2 1@0 0",
               n_rdy, rdy_at, n_drdy, drdy_at, wsb.size());
    end
    clear_inputs();
  endtask

  task automatic test_arbitration();
    beat_t e;
    logic exp_dc;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
`ifdef MEM_ARB_RR_EN
      exp_dc = (r != 1);
`else
      exp_dc = 1'b1;
`endif
      ic_if.req_valid = 1'b1; ic_if.req_addr = 28'h0000100;
      dc_if.req_valid = 1'b1; dc_if.req_addr = 28'h0000200;
      mem_if.req_ready = 1'b1;
      @(negedge clk); #1;
      vectors++;
      if (mem_if.req_addr !== (exp_dc ? 28'h0000200 : 28'h0000100) ||
          {ic_if.req_ready, dc_if.req_ready} !== {!exp_dc, exp_dc}) begin
        miscompares++;
        $display("FAIL arb_grant%0d: addr=%h ic_rdy=%b dc_rdy=%b, required dc=%b", r,
                 mem_if.req_addr, ic_if.req_ready, dc_if.req_ready, exp_dc);
      end
      @(negedge clk);
      ic_if.req_valid = 1'b0; dc_if.req_valid = 1'b0; mem_if.req_ready = 1'b0;
      for (int i = 0; i < RB; i++) begin
        mem_if.resp_valid = 1'b1;
        mem_if.resp_data  = DB'(32'h100 * r + i);
        sb.push_back('{port: exp_dc, data: DB'(32'h100 * r + i)});
        #1;
        vectors++;
        e = sb.pop_front();
        if (ic_if.resp_valid !== !e.port || dc_if.resp_valid !== e.port ||
            (e.port ? dc_if.resp_data : ic_if.resp_data) !== e.data) begin
          miscompares++;
          $display("FAIL arb_beat%0d_%0d: ic=%b dc=%b, required ic=%b dc=%b data=%h", r, i,
                   ic_if.resp_valid, dc_if.resp_valid, !e.port, e.port, e.data);
        end
        @(negedge clk);
      end
      mem_if.resp_valid = 1'b0;
    end
    clear_inputs();
  endtask

  task automatic test_stray();
    beat_t e;
    mem_if.resp_valid = 1'b1; mem_if.resp_data = DB'(32'hBAD);
    #1;
    vectors++;
    if (ic_if.resp_valid || dc_if.resp_valid) begin
      miscompares++;
      $display("FAIL stray_idle: ic=%b dc=%b, required 0 0", ic_if.resp_valid, dc_if.resp_valid);
    end
    @(negedge clk);
    ic_if.req_valid = 1'b1; ic_if.req_addr = 28'h0000300;
    @(negedge clk);
    mem_if.req_ready = 1'b1;
    #1;
    vectors++;
    if (ic_if.resp_valid || dc_if.resp_valid) begin
      miscompares++;
      $display("FAIL stray_addr: ic=%b dc=%b, required 0 0", ic_if.resp_valid, dc_if.resp_valid);
    end
    @(negedge clk);
    ic_if.req_valid = 1'b0; mem_if.req_ready = 1'b0;
    for (int i = 0; i < RB + 1; i++) begin
      mem_if.resp_valid = 1'b1;
      mem_if.resp_data  = DB'(32'h30 + i);
      if (i < RB) sb.push_back('{port: 1'b0, data: DB'(32'h30 + i)});
      #1;
      vectors++;
      if (sb.size() == 0) begin
        if (ic_if.resp_valid || dc_if.resp_valid) begin
          miscompares++;
          $display("FAIL stray_extra_beat: ic=%b dc=%b, required 0 0", ic_if.resp_valid, dc_if.resp_valid);
        end
      end else begin
        e = sb.pop_front();
        if (ic_if.resp_valid !== 1'b1 || dc_if.resp_valid !== 1'b0 || ic_if.resp_data !== e.data) begin
          miscompares++;
          $display("FAIL stray_beat%0d: ic=%b dc=%b data=%h, required 1 0 %h", i,
                   ic_if.resp_valid, dc_if.resp_valid, ic_if.resp_data, e.data);
        end
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_read();
    beat_t e;
    ic_if.req_valid = 1'b1; ic_if.req_addr = 28'h0000400; mem_if.req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ic_if.req_valid = 1'b0; mem_if.req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_if.resp_valid = 1'b1; mem_if.resp_data = DB'(32'h40 + i);
      sb.push_back('{port: 1'b0, data: DB'(32'h40 + i)});
      #1;
      vectors++;
      e = sb.pop_front();
      if (ic_if.resp_valid !== 1'b1 || ic_if.resp_data !== e.data) begin
        miscompares++;
        $display("FAIL rst_pre_beat%0d: ic=%b data=%h, required 1 %h", i, ic_if.resp_valid, ic_if.resp_data, e.data);
      end
      @(negedge clk);
    end
    ic_if.req_valid = 1'b1; dc_if.req_valid = 1'b1;
    mem_if.req_ready = 1'b1; mem_if.req_data_ready = 1'b1; mem_if.resp_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ic_if.req_ready, ic_if.req_data_ready, ic_if.resp_valid, dc_if.req_ready,
         dc_if.req_data_ready, dc_if.resp_valid, mem_if.req_valid, mem_if.req_data_valid} !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_async: got %b %b %b %b %b %b %b %b, required all 0",
               ic_if.req_ready, ic_if.req_data_ready, ic_if.resp_valid, dc_if.req_ready,
               dc_if.req_data_ready, dc_if.resp_valid, mem_if.req_valid, mem_if.req_data_valid);
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    dc_if.req_valid = 1'b1; dc_if.req_addr = 28'h0000500; mem_if.req_ready = 1'b1;
    mem_if.resp_valid = 1'b1; mem_if.resp_data = DB'(32'h42);
    #1;
    vectors++;
    if (ic_if.resp_valid || dc_if.resp_valid) begin
      miscompares++;
      $display("FAIL rst_drop_beat3: ic=%b dc=%b, required 0 0", ic_if.resp_valid, dc_if.resp_valid);
    end
    @(negedge clk);
    mem_if.resp_data = DB'(32'h43);
    #1;
    vectors++;
    if (ic_if.resp_valid || dc_if.resp_valid || mem_if.req_addr !== 28'h0000500 || dc_if.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_regrant: ic=%b dc=%b addr=%h dc_rdy=%b, required 0 0 0000500 1",
               ic_if.resp_valid, dc_if.resp_valid, mem_if.req_addr, dc_if.req_ready);
    end
    @(negedge clk);
    dc_if.req_valid = 1'b0; mem_if.req_ready = 1'b0;
    for (int i = 0; i < RB; i++) begin
      mem_if.resp_valid = 1'b1; mem_if.resp_data = DB'(32'h50 + i);
      sb.push_back('{port: 1'b1, data: DB'(32'h50 + i)});
      #1;
      vectors++;
      e = sb.pop_front();
      if (dc_if.resp_valid !== 1'b1 || ic_if.resp_valid !== 1'b0 || dc_if.resp_data !== e.data) begin
        miscompares++;
        $display("FAIL rst_post_beat%0d: ic=%b dc=%b data=%h, required 0 1 %h", i,
                 ic_if.resp_valid, dc_if.resp_valid, dc_if.resp_data, e.data);
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_abandon();
    beat_t e;
    ic_if.req_valid = 1'b1; ic_if.req_addr = 28'h0000600; mem_if.req_ready = 1'b0;
    @(negedge clk);
    dc_if.req_valid = 1'b1; dc_if.req_addr = 28'h0000700;
    #1;
    vectors++;
    if (mem_if.req_valid !== 1'b1 || mem_if.req_addr !== 28'h0000600) begin
      miscompares++;
      $display("FAIL abandon_own: valid=%b addr=%h, required 1 0000600", mem_if.req_valid, mem_if.req_addr);
    end
    @(negedge clk);
    ic_if.req_valid = 1'b0;
    #1;
    vectors++;
    if (mem_if.req_valid !== 1'b0 || ic_if.req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL abandon_drop: valid=%b ic_rdy=%b, required 0 0", mem_if.req_valid, ic_if.req_ready);
    end
    @(negedge clk);
    @(negedge clk);
    mem_if.req_ready = 1'b1;
    #1;
    vectors++;
    if (mem_if.req_valid !== 1'b1 || mem_if.req_addr !== 28'h0000700 || {ic_if.req_ready, dc_if.req_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL abandon_regrant: valid=%b addr=%h ic_rdy=%b dc_rdy=%b, required 1 0000700 0 1",
               mem_if.req_valid, mem_if.req_addr, ic_if.req_ready, dc_if.req_ready);
    end
    @(negedge clk);
    dc_if.req_valid = 1'b0; mem_if.req_ready = 1'b0;
    for (int i = 0; i < RB; i++) begin
      mem_if.resp_valid = 1'b1; mem_if.resp_data = DB'(32'h70 + i);
      sb.push_back('{port: 1'b1, data: DB'(32'h70 + i)});
      #1;
      vectors++;
      e = sb.pop_front();
      if (dc_if.resp_valid !== 1'b1 || ic_if.resp_valid !== 1'b0 || dc_if.resp_data !== e.data) begin
        miscompares++;
        $display("FAIL abandon_beat%0d: ic=%b dc=%b data=%h, required 0 1 %h", i,
                 ic_if.resp_valid, dc_if.resp_valid, dc_if.resp_data, e.data);
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_read();
    test_write();
    test_arbitration();
    test_stray();
    test_reset_mid_read();
    test_abandon();
    vectors++;
    if (sb.size() != 0 || wsb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: pending beats %0d writes %0d, required 0 0", sb.size(), wsb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
